robo_mission_ctrl: RTL
======================

ROBO_MISSION_CTRL -- requirements
Module: robo_mission_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, launch a mission; honoured only in IDLE, DONE or FAULT.
REQ-004 SHALL have port abort, input, 1, cancel the mission from any state.
REQ-005 SHALL have port init_row, input, 4, start row (legal 1..10).
REQ-006 SHALL have port init_col, input, 5, start column (legal 1..20).
REQ-007 SHALL have port init_dir, input, 2, start orientation: 00 north, 01 south, 10 east, 11 west.
REQ-008 SHALL have port max_moves, input, 9, movement budget.
REQ-009 SHALL have ports front, turn and remove, input, 1 each, robot-core decisions, valid in ACT.
REQ-010 SHALL have port sense_req, output, 1, high in SENSE only: sensor model drives head/left/under/barrier for the current pose.
REQ-011 SHALL have port row, output, 4, current row.
REQ-012 SHALL have port col, output, 5, current column.
REQ-013 SHALL have port dir, output, 2, current orientation.
REQ-014 SHALL have port move_cnt, output, 9, movements completed.
REQ-015 SHALL have port removed_cnt, output, 8, removal count.
REQ-016 SHALL have ports busy, done and fault, output, 1 each, status flags.

Function
REQ-017 SHALL implement FSM states IDLE, SENSE, ACT, DONE and FAULT.
REQ-018 IDLE/DONE/FAULT + start: load pose from init_*, clear move_cnt and removed_cnt, go to SENSE.
REQ-019 Start with init_row outside 1..10 or init_col outside 1..20 SHALL load the pose and go to FAULT.
REQ-020 Start with max_moves=0 SHALL go to DONE.
REQ-021 SENSE SHALL last exactly one cycle, then go to ACT; one movement takes 2 cycles.
REQ-022 ACT, front=1 SHALL step: north row-1, south row+1, east col+1, west col-1.
REQ-023 ACT, front=0 and turn=1 SHALL rotate: N->W, W->S, S->E, E->N.
REQ-024 ACT, front=1 and turn=1 SHALL act as front only.
REQ-025 ACT, neither asserted SHALL leave the pose unchanged.
REQ-026 ACT SHALL increment move_cnt every cycle it is entered, including with no action.
REQ-027 ACT, remove=1 SHALL increment removed_cnt, saturating at 255; remove is independent of front/turn.
REQ-028 A step leaving rows 1..10 or columns 1..20 SHALL go to FAULT with the pose unchanged; move_cnt still increments.
REQ-029 Otherwise, ACT SHALL go to DONE when the incremented move_cnt equals max_moves, else to SENSE.
REQ-030 start, init_* and max_moves SHALL be sampled only on launch; later changes are ignored.
REQ-031 abort SHALL force IDLE next edge and take priority over start; pose and counters hold their values.
REQ-032 busy=1 in SENSE/ACT; done=1 in DONE; fault=1 in FAULT; all registered.

Reset
REQ-033 reset low SHALL immediately force IDLE, row=1, col=1, dir=00, move_cnt=0, removed_cnt=0, sense_req=0, busy=0, done=0, fault=0.
REQ-034 reset mid-mission SHALL discard the mission; a new start is required after release.

Configuration
REQ-035 Macro ROBO_REMOVE_COUNT_EN defined SHALL include the removed_cnt counter per REQ-027.
REQ-036 Macro ROBO_REMOVE_COUNT_EN undefined SHALL tie removed_cnt to 0 and ignore remove; all other behaviour is identical.

Verification
REQ-037 Start (5,5,north,max 3), front=1 each ACT -> rows 4,3,2; done after 6 cycles; move_cnt=3.
REQ-038 Start (1,1,north,max 4), front=0, turn=1 -> dir W,S,E,N; pose (1,1); done.
REQ-039 Start (1,20,east,max 5), front=1 -> FAULT after the first ACT; col=20; move_cnt=1.
REQ-040 Start init_row=0 -> FAULT next edge, sense_req never asserted; start with max_moves=0 -> DONE.
REQ-041 remove=1 for 300 ACTs (max 300) -> removed_cnt=255 with the macro, 0 without.
REQ-042 abort plus start in SENSE -> IDLE; reset low in ACT -> immediate IDLE, outputs at reset values.

Source files
------------

// File: rtl/robo_mission_ctrl.sv
// Mission sequencer for a grid robot: launches a pose, alternates SENSE/ACT per movement,
// tracks the movement budget and faults on grid exits. Optional macro ROBO_REMOVE_COUNT_EN.
module robo_mission_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] init_row,
    input  logic [4:0] init_col,
    input  logic [1:0] init_dir,
    input  logic [8:0] max_moves,
    input  logic       front,
    input  logic       turn,
    input  logic       remove,
    output logic       sense_req,
    output logic [3:0] row,
    output logic [4:0] col,
    output logic [1:0] dir,
    output logic [8:0] move_cnt,
    output logic [7:0] removed_cnt,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {IDLE, SENSE, ACT, DONE, FAULT} state_t;

    state_t     state;
    logic [8:0] max_reg;
    logic [4:0] step_row;
    logic [5:0] step_col;
    logic       step_ok;
    logic [1:0] turn_dir;
    logic       launch_bad;
    logic [8:0] move_inc;

    // Candidate step is computed one bit wider so that 1-1 and 10+1 fall outside the grid.
    always_comb begin
        step_row = {1'b0, row};
        step_col = {1'b0, col};
        case (dir)
            2'b00:   step_row = {1'b0, row} - 5'd1;
            2'b01:   step_row = {1'b0, row} + 5'd1;
            2'b10:   step_col = {1'b0, col} + 6'd1;
            default: step_col = {1'b0, col} - 6'd1;
        endcase
        step_ok = (step_row >= 5'd1) && (step_row <= 5'd10) &&
                  (step_col >= 6'd1) && (step_col <= 6'd20);
        case (dir)
            2'b00:   turn_dir = 2'b11;
            2'b11:   turn_dir = 2'b01;
            2'b01:   turn_dir = 2'b10;
            default: turn_dir = 2'b00;
        endcase
    end

    assign launch_bad = (init_row == 4'd0) || (init_row > 4'd10) ||
                        (init_col == 5'd0) || (init_col > 5'd20);
    assign move_inc   = move_cnt + 9'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= 4'd1;
            col       <= 5'd1;
            dir       <= 2'b00;
            move_cnt  <= 9'd0;
            max_reg   <= 9'd0;
            sense_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
`ifdef ROBO_REMOVE_COUNT_EN
            removed_cnt <= 8'd0;
`endif
        end else if (abort) begin
            state     <= IDLE;
            sense_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                SENSE: begin
                    state     <= ACT;
                    sense_req <= 1'b0;
                end
                ACT: begin
                    move_cnt <= move_inc;
`ifdef ROBO_REMOVE_COUNT_EN
                    if (remove && (removed_cnt != 8'hFF))
                        removed_cnt <= removed_cnt + 8'd1;
`endif
                    if (front && !step_ok) begin
                        state <= FAULT;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        if (front) begin
                            row <= step_row[3:0];
                            col <= step_col[4:0];
                        end else if (turn) begin
                            dir <= turn_dir;
                        end
                        if (move_inc == max_reg) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= SENSE;
                            sense_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        row      <= init_row;
                        col      <= init_col;
                        dir      <= init_dir;
                        move_cnt <= 9'd0;
                        max_reg  <= max_moves;
`ifdef ROBO_REMOVE_COUNT_EN
                        removed_cnt <= 8'd0;
`endif
                        if (launch_bad) begin
                            state     <= FAULT;
                            sense_req <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b0;
                            fault     <= 1'b1;
                        end else if (max_moves == 9'd0) begin
                            state     <= DONE;
                            sense_req <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fault     <= 1'b0;
                        end else begin
                            state     <= SENSE;
                            sense_req <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            fault     <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifndef ROBO_REMOVE_COUNT_EN
    logic unused_remove;
    assign unused_remove = remove;
    assign removed_cnt   = 8'd0;
`endif

endmodule
